rv32_mc_control: RTL and testbench
==================================

Name: rv32_mc_control

Overview:
- Multicycle RV32I control unit: the initiator that drives the ALU's `control` input and consumes its `zero`/`equal`/`result` flags.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Emits all datapath enables and mux selects.
- Sits between the instruction register, the ALU, the register file and a single shared instruction/data memory port.

Parameters:
- `RESET_STATE`, `S_FETCH`: state entered on reset.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `instr`  in  32  current instruction-register contents.
- `alu_zero`  in  1  ALU zero flag.
- `alu_equal`  in  1  ALU equal flag (a == b).
- `alu_lsb`  in  1  ALU `result[0]`; SLT/SLTU outcome.
- `mem_ready`  in  1  memory completed the requested access this cycle.
- `alu_control`  out  `alu_control_t`  ALU operation.
- `alu_src_a`  out  2  00 PC, 01 old_PC, 10 rs1 register, 11 zero.
- `alu_src_b`  out  2  00 rs2 register, 01 imm_ext, 10 constant 4.
- `imm_src`  out  3  0 I, 1 S, 2 B, 3 J, 4 U.
- `result_src`  out  2  00 alu_out register, 01 mem data, 10 live ALU result.
- `adr_src`  out  1  0 PC, 1 result bus.
- `mem_req`  out  1  memory access request.
- `mem_wr_ena`  out  1  memory write.
- `ir_ena`  out  1  load IR and old_PC.
- `pc_ena`  out  1  load PC from result bus.
- `reg_wr_ena`  out  1  register-file write.
- `illegal`  out  1  sticky unsupported-opcode flag.
- `state`  out  4  current FSM state, for debug.

Behaviour:
- Single registered state; all outputs are combinational decodes of `state`, plus `instr` fields where noted.
- Reset:
  - `rst` high at a clock edge forces `S_FETCH` and clears `illegal`.
  - `rst` overrides any in-flight instruction; no partial writeback completes after the reset edge.
  - While in reset, all enables (`mem_req`, `mem_wr_ena`, `ir_ena`, `pc_ena`, `reg_wr_ena`) = 0.
  - `alu_control` = `ALU_ADD`; all selects = 0.
- State transitions:
  - `S_FETCH`:
    - Outputs: `mem_req`=1, `adr_src`=0, `alu_src_a`=PC, `alu_src_b`=4, `ALU_ADD`, `result_src`=10.
    - While `mem_ready`=0: hold; `ir_ena`=`pc_ena`=0.
    - When `mem_ready`=1: `ir_ena`=1, `pc_ena`=1, go to `S_DECODE`.
  - `S_DECODE`:
    - Outputs: `alu_src_a`=old_PC, `alu_src_b`=imm, `imm_src`=B, `ALU_ADD` (precomputes branch target into alu_out).
    - Next state by `opcode` (`instr[6:0]`): load/store → `S_MEM_ADR`; R-type → `S_EXEC_R`; I-ALU → `S_EXEC_I`; JAL → `S_JAL`; JALR → `S_JALR`; branch → `S_BRANCH`; LUI → `S_LUI`; anything else → `S_ERROR`.
  - `S_MEM_ADR`:
    - Outputs: rs1 + imm; `imm_src` I for loads, S for stores; `ALU_ADD`.
    - Next: `S_MEM_READ` (loads) or `S_MEM_WRITE` (stores).
  - `S_MEM_READ`:
    - Outputs: `adr_src`=1, `mem_req`=1, `result_src`=00.
    - Holds until `mem_ready`, then goes to `S_MEM_WB`.
  - `S_MEM_WB`: `result_src`=01, `reg_wr_ena`=1; next `S_FETCH`.
  - `S_MEM_WRITE`:
    - Outputs: `adr_src`=1, `mem_req`=1, `mem_wr_ena`=1.
    - Holds until `mem_ready`, then goes to `S_FETCH`.
  - `S_EXEC_R`:
    - Operands: rs1 op rs2.
    - funct3/funct7 map: 000 → ADD, or SUB when `funct7[5]`; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 → SRL, or SRA when `funct7[5]`; 110 OR; 111 AND.
    - Next: `S_ALU_WB`.
  - `S_EXEC_I`:
    - Operands: rs1 op imm (`imm_src` I), same map.
    - funct7 is ignored except for 101, where `instr[30]` selects SRA; ADDI never subtracts.
    - Next: `S_ALU_WB`.
  - `S_ALU_WB`: `result_src`=00, `reg_wr_ena`=1; next `S_FETCH`.
  - `S_JAL`:
    - Outputs: old_PC + 4 computed live; `pc_ena`=1 with `result_src`=00 (branch target computed in DECODE with J-imm; DECODE uses `imm_src` J when opcode = JAL).
    - Next: `S_ALU_WB`.
  - `S_JALR`:
    - Outputs: rs1 + I-imm; `pc_ena`=1, `result_src`=10.
    - Next: `S_JALR_WB`.
  - `S_JALR_WB`:
    - Outputs: old_PC + 4, `result_src`=10, `reg_wr_ena`=1.
    - Next: `S_FETCH`.
  - `S_BRANCH`:
    - Operands: rs1 vs rs2.
    - funct3 → ALU op: BEQ/BNE use SUB; BLT/BGE use SLT; BLTU/BGEU use SLTU.
    - Taken when: BEQ `alu_equal`; BNE `~alu_equal`; BLT/BLTU `alu_lsb`; BGE/BGEU `~alu_lsb`.
    - `pc_ena` = taken, with `result_src`=00.
    - Next: `S_FETCH`.
  - `S_LUI`: zero + U-imm; next `S_ALU_WB`.
  - `S_ERROR`: `illegal`=1, all enables 0, absorbing until `rst`.
- Latency with `mem_ready` tied high:
  - R/I/LUI/JAL: 4 cycles.
  - JALR: 4 cycles.
  - Branch: 3 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Each memory wait cycle adds exactly 1 cycle.
- Handshake: `mem_req` stays asserted and the address source stays stable until the cycle in which `mem_ready`=1.
- Unsupported funct3 in branch (010, 011) or load/store width: treated as illegal → `S_ERROR`.
- `alu_control` encoding: `ALU_ADD` is 4'b1000 and `ALU_SUB` is 4'b1100. These bit patterns are required because the ALU derives overflow from `control[3:2]`.

Decomposition:
- Shared package `rv32_types_pkg`: `opcode_t` enum, funct3 constants, `state_t` enum, and selector enums `alu_src_a_t`, `alu_src_b_t`, `imm_src_t`, `result_src_t`.
- `alu_control_t` is reused from `alu_types`.
- One sub-module: `rv32_alu_decoder`, a combinational funct3/funct7/op-class → `alu_control_t` mapping, shared by EXEC_R, EXEC_I and BRANCH.

Test Plan:
- `rst`=1 for 2 cycles mid-EXEC_R → next cycle `state`=S_FETCH, `reg_wr_ena`=0, `illegal`=0, `mem_req`=1.
- `instr`=0x002081B3 (add x3,x1,x2), `mem_ready`=1 → states FETCH, DECODE, EXEC_R, ALU_WB; `alu_control`=ADD (4'b1000) in EXEC_R; `reg_wr_ena`=1 only in cycle 4.
  - Same with 0x402081B3 → `alu_control`=SUB (4'b1100).
- `instr`=0x0040A283 (lw x5,4(x1)) with `mem_ready` low for 3 cycles in MEM_READ → MEM_READ held exactly 4 cycles; `mem_req`=1 throughout; `reg_wr_ena`=1 once, in MEM_WB.
- `instr`=0x00000063 (beq x0,x0,0) with `alu_equal`=1 → `pc_ena`=1 in BRANCH; with `alu_equal`=0 → `pc_ena`=0. Both paths: 3 cycles total.
- `instr`=0x00000000 → DECODE then S_ERROR; `illegal`=1 and all enables 0 for 10+ cycles, until `rst`.

Source files
------------

// File: rtl/alu_types.sv
// ALU operation encoding shared by the ALU and its controllers.
// ADD/SUB bit patterns are fixed: the ALU derives overflow from control[3:2].
package alu_types;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_ADD  = 4'b1000,
        ALU_SUB  = 4'b1100
    } alu_control_t;

endpackage

// File: rtl/rv32_types_pkg.sv
// RV32I control-path types: opcodes, funct3 constants, FSM states and datapath selectors.
package rv32_types_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned STATE_W = 4;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_OP     = 7'b0110011,
        OP_IMM    = 7'b0010011,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LUI    = 7'b0110111
    } opcode_t;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADR   = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_JAL       = 4'd9,
        S_JALR      = 4'd10,
        S_JALR_WB   = 4'd11,
        S_BRANCH    = 4'd12,
        S_LUI       = 4'd13,
        S_ERROR     = 4'd14
    } state_t;

    localparam state_t RESET_STATE = S_FETCH;

    typedef enum logic [1:0] {
        SRC_A_PC     = 2'b00,
        SRC_A_OLD_PC = 2'b01,
        SRC_A_RS1    = 2'b10,
        SRC_A_ZERO   = 2'b11
    } alu_src_a_t;

    typedef enum logic [1:0] {
        SRC_B_RS2  = 2'b00,
        SRC_B_IMM  = 2'b01,
        SRC_B_FOUR = 2'b10
    } alu_src_b_t;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_J = 3'd3,
        IMM_U = 3'd4
    } imm_src_t;

    typedef enum logic [1:0] {
        RES_ALU_OUT = 2'b00,
        RES_MEM     = 2'b01,
        RES_ALU     = 2'b10
    } result_src_t;

    typedef enum logic [1:0] {
        ALU_CLASS_R      = 2'd0,
        ALU_CLASS_I      = 2'd1,
        ALU_CLASS_BRANCH = 2'd2
    } alu_class_t;

endpackage

// File: rtl/rv32_alu_decoder.sv
// funct3/funct7 + operation class -> ALU operation, shared by EXEC_R, EXEC_I and BRANCH.
module rv32_alu_decoder
    import alu_types::*;
    import rv32_types_pkg::*;
(
    input  logic [1:0] i_alu_class,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7_b5,
    output logic [3:0] o_alu_control
);

    alu_control_t w_op;

    always_comb begin
        w_op = ALU_ADD;
        if (i_alu_class == ALU_CLASS_BRANCH) begin
            // Equality compares subtract; signed/unsigned orderings use the set-less-than ops.
            case (i_funct3[2:1])
                2'b10:   w_op = ALU_SLT;
                2'b11:   w_op = ALU_SLTU;
                default: w_op = ALU_SUB;
            endcase
        end else begin
            case (i_funct3)
                F3_ADD_SUB: w_op = (i_alu_class == ALU_CLASS_R && i_funct7_b5) ? ALU_SUB : ALU_ADD;
                F3_SLL:     w_op = ALU_SLL;
                F3_SLT:     w_op = ALU_SLT;
                F3_SLTU:    w_op = ALU_SLTU;
                F3_XOR:     w_op = ALU_XOR;
                F3_SRL_SRA: w_op = i_funct7_b5 ? ALU_SRA : ALU_SRL;
                F3_OR:      w_op = ALU_OR;
                default:    w_op = ALU_AND;
            endcase
        end
    end

    assign o_alu_control = w_op;

endmodule

// File: rtl/rv32_mc_control.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback and
// drives every datapath enable and mux select as a decode of the current state.
module rv32_mc_control
    import alu_types::*;
    import rv32_types_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_instr,
    input  logic        i_alu_zero,
    input  logic        i_alu_equal,
    input  logic        i_alu_lsb,
    input  logic        i_mem_ready,
    output logic [3:0]  o_alu_control,
    output logic [1:0]  o_alu_src_a,
    output logic [1:0]  o_alu_src_b,
    output logic [2:0]  o_imm_src,
    output logic [1:0]  o_result_src,
    output logic        o_adr_src,
    output logic        o_mem_req,
    output logic        o_mem_wr_ena,
    output logic        o_ir_ena,
    output logic        o_pc_ena,
    output logic        o_reg_wr_ena,
    output logic        o_illegal,
    output logic [3:0]  o_state
);

    state_t      r_state;
    state_t      w_state_next;
    logic        r_illegal;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic        w_load_ok;
    logic        w_store_ok;
    logic        w_branch_ok;
    logic        w_taken;
    alu_class_t  w_alu_class;
    logic [3:0]  w_dec_alu;

    logic [3:0]  w_alu_control;
    alu_src_a_t  w_src_a;
    alu_src_b_t  w_src_b;
    imm_src_t    w_imm_src;
    result_src_t w_result_src;
    logic        w_adr_src;
    logic        w_mem_req;
    logic        w_mem_wr_ena;
    logic        w_ir_ena;
    logic        w_pc_ena;
    logic        w_reg_wr_ena;
    logic        w_unused;

    assign w_opcode = i_instr[6:0];
    assign w_funct3 = i_instr[14:12];
    assign w_unused = ^{i_alu_zero, i_instr[31], i_instr[29:15], i_instr[11:7]};

    // Supported widths: loads B/H/W/BU/HU, stores B/H/W; branch funct3 010/011 are undefined.
    assign w_load_ok   = (w_funct3 != 3'b011) && (w_funct3[2:1] != 2'b11);
    assign w_store_ok  = !w_funct3[2] && (w_funct3 != 3'b011);
    assign w_branch_ok = (w_funct3[2:1] != 2'b01);

    // funct3[0] inverts the sense: BNE/BGE/BGEU are the complements of BEQ/BLT/BLTU.
    assign w_taken = w_funct3[2] ? (i_alu_lsb ^ w_funct3[0]) : (i_alu_equal ^ w_funct3[0]);

    assign w_alu_class = (r_state == S_EXEC_I) ? ALU_CLASS_I :
                         (r_state == S_BRANCH) ? ALU_CLASS_BRANCH : ALU_CLASS_R;

    rv32_alu_decoder u_alu_decoder (
        .i_alu_class   (w_alu_class),
        .i_funct3      (w_funct3),
        .i_funct7_b5   (i_instr[30]),
        .o_alu_control (w_dec_alu)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= RESET_STATE;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_state_next == S_ERROR) begin
                r_illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_alu_control = ALU_ADD;
        w_src_a       = SRC_A_PC;
        w_src_b       = SRC_B_RS2;
        w_imm_src     = IMM_I;
        w_result_src  = RES_ALU_OUT;
        w_adr_src     = 1'b0;
        w_mem_req     = 1'b0;
        w_mem_wr_ena  = 1'b0;
        w_ir_ena      = 1'b0;
        w_pc_ena      = 1'b0;
        w_reg_wr_ena  = 1'b0;
        if (!i_rst) begin
            case (r_state)
                S_FETCH: begin
                    w_mem_req    = 1'b1;
                    w_src_b      = SRC_B_FOUR;
                    w_result_src = RES_ALU;
                    if (i_mem_ready) begin
                        w_ir_ena     = 1'b1;
                        w_pc_ena     = 1'b1;
                        w_state_next = S_DECODE;
                    end
                end
                S_DECODE: begin
                    // Branch/JAL target lands in alu_out for the following state.
                    w_src_a   = SRC_A_OLD_PC;
                    w_src_b   = SRC_B_IMM;
                    w_imm_src = (w_opcode == OP_JAL) ? IMM_J : IMM_B;
                    case (w_opcode)
                        OP_LOAD:   w_state_next = w_load_ok ? S_MEM_ADR : S_ERROR;
                        OP_STORE:  w_state_next = w_store_ok ? S_MEM_ADR : S_ERROR;
                        OP_OP:     w_state_next = S_EXEC_R;
                        OP_IMM:    w_state_next = S_EXEC_I;
                        OP_JAL:    w_state_next = S_JAL;
                        OP_JALR:   w_state_next = S_JALR;
                        OP_BRANCH: w_state_next = w_branch_ok ? S_BRANCH : S_ERROR;
                        OP_LUI:    w_state_next = S_LUI;
                        default:   w_state_next = S_ERROR;
                    endcase
                end
                S_MEM_ADR: begin
                    w_src_a      = SRC_A_RS1;
                    w_src_b      = SRC_B_IMM;
                    w_imm_src    = (w_opcode == OP_STORE) ? IMM_S : IMM_I;
                    w_state_next = (w_opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
                end
                S_MEM_READ: begin
                    w_adr_src = 1'b1;
                    w_mem_req = 1'b1;
                    if (i_mem_ready) begin
                        w_state_next = S_MEM_WB;
                    end
                end
                S_MEM_WB: begin
                    w_result_src = RES_MEM;
                    w_reg_wr_ena = 1'b1;
                    w_state_next = S_FETCH;
                end
                S_MEM_WRITE: begin
                    w_adr_src    = 1'b1;
                    w_mem_req    = 1'b1;
                    w_mem_wr_ena = 1'b1;
                    if (i_mem_ready) begin
                        w_state_next = S_FETCH;
                    end
                end
                S_EXEC_R: begin
                    w_src_a       = SRC_A_RS1;
                    w_alu_control = w_dec_alu;
                    w_state_next  = S_ALU_WB;
                end
                S_EXEC_I: begin
                    w_src_a       = SRC_A_RS1;
                    w_src_b       = SRC_B_IMM;
                    w_alu_control = w_dec_alu;
                    w_state_next  = S_ALU_WB;
                end
                S_ALU_WB: begin
                    w_reg_wr_ena = 1'b1;
                    w_state_next = S_FETCH;
                end
                S_JAL: begin
                    // Jump to the DECODE-computed target while forming the link value.
                    w_src_a      = SRC_A_OLD_PC;
                    w_src_b      = SRC_B_FOUR;
                    w_pc_ena     = 1'b1;
                    w_state_next = S_ALU_WB;
                end
                S_JALR: begin
                    w_src_a      = SRC_A_RS1;
                    w_src_b      = SRC_B_IMM;
                    w_result_src = RES_ALU;
                    w_pc_ena     = 1'b1;
                    w_state_next = S_JALR_WB;
                end
                S_JALR_WB: begin
                    w_src_a      = SRC_A_OLD_PC;
                    w_src_b      = SRC_B_FOUR;
                    w_result_src = RES_ALU;
                    w_reg_wr_ena = 1'b1;
                    w_state_next = S_FETCH;
                end
                S_BRANCH: begin
                    w_src_a       = SRC_A_RS1;
                    w_alu_control = w_dec_alu;
                    w_pc_ena      = w_taken;
                    w_state_next  = S_FETCH;
                end
                S_LUI: begin
                    w_src_a      = SRC_A_ZERO;
                    w_src_b      = SRC_B_IMM;
                    w_imm_src    = IMM_U;
                    w_state_next = S_ALU_WB;
                end
                S_ERROR: w_state_next = S_ERROR;
                default: w_state_next = S_FETCH;
            endcase
        end
    end

    assign o_alu_control = w_alu_control;
    assign o_alu_src_a   = w_src_a;
    assign o_alu_src_b   = w_src_b;
    assign o_imm_src     = w_imm_src;
    assign o_result_src  = w_result_src;
    assign o_adr_src     = w_adr_src;
    assign o_mem_req     = w_mem_req;
    assign o_mem_wr_ena  = w_mem_wr_ena;
    assign o_ir_ena      = w_ir_ena;
    assign o_pc_ena      = w_pc_ena;
    assign o_reg_wr_ena  = w_reg_wr_ena;
    assign o_illegal     = r_illegal;
    assign o_state       = r_state;

endmodule

// File: tb/tb_rv32_mc_control.sv
// Bench for rv32_mc_control: directed scenarios plus random instruction streams
// checked against a per-instruction phase-list model.
module tb_rv32_mc_control;
    import alu_types::*;
    import rv32_types_pkg::*;

    localparam logic [1:0] A_PC = 2'b00, A_OLD = 2'b01, A_RS1 = 2'b10, A_ZERO = 2'b11;
    localparam logic [1:0] B_RS2 = 2'b00, B_IMM = 2'b01, B_FOUR = 2'b10;
    localparam logic [2:0] I_I = 3'd0, I_S = 3'd1, I_B = 3'd2, I_J = 3'd3, I_U = 3'd4;
    localparam logic [1:0] R_AOUT = 2'b00, R_MEM = 2'b01, R_ALU = 2'b10;
    localparam logic [3:0] OPC_ADD = 4'b1000, OPC_SUB = 4'b1100;

    typedef struct packed {
        logic [3:0] st;
        logic [3:0] alu;
        logic [1:0] ra;
        logic [1:0] rb;
        logic [2:0] imm;
        logic [1:0] rs;
        logic       adr;
        logic       req;
        logic       wr;
        logic       ir;
        logic       pc;
        logic       regw;
        logic       ill;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = '0;
    logic        alu_zero = 1'b0, alu_equal = 1'b0, alu_lsb = 1'b0, mem_ready = 1'b0;
    logic [3:0]  alu_control;
    logic [1:0]  alu_src_a, alu_src_b, result_src;
    logic [2:0]  imm_src;
    logic        adr_src, mem_req, mem_wr_ena, ir_ena, pc_ena, reg_wr_ena, illegal;
    logic [3:0]  state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rv32_mc_control dut (
        .i_clk(clk), .i_rst(rst), .i_instr(instr), .i_alu_zero(alu_zero),
        .i_alu_equal(alu_equal), .i_alu_lsb(alu_lsb), .i_mem_ready(mem_ready),
        .o_alu_control(alu_control), .o_alu_src_a(alu_src_a), .o_alu_src_b(alu_src_b),
        .o_imm_src(imm_src), .o_result_src(result_src), .o_adr_src(adr_src),
        .o_mem_req(mem_req), .o_mem_wr_ena(mem_wr_ena), .o_ir_ena(ir_ena),
        .o_pc_ena(pc_ena), .o_reg_wr_ena(reg_wr_ena), .o_illegal(illegal), .o_state(state)
    );

    // One clock cycle: inputs applied on the falling edge, outputs settled 1 time unit later.
    task automatic cyc(input logic r, input logic rdy, input logic eq, input logic lsb,
                       input logic [31:0] ins);
        @(negedge clk);
        rst = r; mem_ready = rdy; alu_equal = eq; alu_lsb = lsb; instr = ins;
        alu_zero = 1'($urandom);
        #1;
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.st = state; o.alu = alu_control; o.ra = alu_src_a; o.rb = alu_src_b;
        o.imm = imm_src; o.rs = result_src; o.adr = adr_src; o.req = mem_req;
        o.wr = mem_wr_ena; o.ir = ir_ena; o.pc = pc_ena; o.regw = reg_wr_ena; o.ill = illegal;
        return o;
    endfunction

    task automatic test_reset();
        logic [31:0] add_i;
        add_i = 32'h002081B3;
        cyc(1'b1, 1'b1, 1'b0, 1'b0, add_i);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, add_i);
        total++;
        if (state !== 4'(S_FETCH) || illegal !== 1'b0) begin
            bad++; $display("FAIL reset_state: state=%0d illegal=%b want %0d/0", state, illegal, S_FETCH);
        end
        total++;
        if ({mem_req, mem_wr_ena, ir_ena, pc_ena, reg_wr_ena} !== 5'b0) begin
            bad++; $display("FAIL reset_enables: got %b want 00000",
                            {mem_req, mem_wr_ena, ir_ena, pc_ena, reg_wr_ena});
        end
        total++;
        if ({alu_control, alu_src_a, alu_src_b, imm_src, result_src, adr_src} !== {OPC_ADD, 10'b0}) begin
            bad++; $display("FAIL reset_selects: alu=%b a=%b b=%b imm=%b res=%b adr=%b",
                            alu_control, alu_src_a, alu_src_b, imm_src, result_src, adr_src);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, add_i);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, add_i);
        total++;
        if (state !== 4'(S_FETCH) || mem_req !== 1'b1 || ir_ena !== 1'b0 || pc_ena !== 1'b0) begin
            bad++; $display("FAIL fetch_hold: state=%0d req=%b ir=%b pc=%b want %0d/1/0/0",
                            state, mem_req, ir_ena, pc_ena, S_FETCH);
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b0, add_i);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, add_i);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, add_i);
        total++;
        if (state !== 4'(S_EXEC_R)) begin
            bad++; $display("FAIL reset_mid_exec_setup: state=%0d want %0d", state, S_EXEC_R);
        end
        cyc(1'b1, 1'b1, 1'b0, 1'b0, add_i);
        total++;
        if (reg_wr_ena !== 1'b0 || mem_req !== 1'b0) begin
            bad++; $display("FAIL reset_mid_exec_enables: regw=%b req=%b want 0/0", reg_wr_ena, mem_req);
        end
        cyc(1'b1, 1'b1, 1'b0, 1'b0, add_i);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, add_i);
        total++;
        if (state !== 4'(S_FETCH) || reg_wr_ena !== 1'b0 || illegal !== 1'b0 || mem_req !== 1'b1) begin
            bad++; $display("FAIL reset_mid_exec: state=%0d regw=%b ill=%b req=%b want %0d/0/0/1",
                            state, reg_wr_ena, illegal, mem_req, S_FETCH);
        end
    endtask

    task automatic test_r_type();
        logic [31:0] ins [2] = '{32'h002081B3, 32'h402081B3};
        logic [3:0]  op  [2] = '{OPC_ADD, OPC_SUB};
        state_t      sq  [5] = '{S_FETCH, S_DECODE, S_EXEC_R, S_ALU_WB, S_FETCH};
        for (int t = 0; t < 2; t++) begin
            do_reset();
            for (int k = 0; k < 5; k++) begin
                cyc(1'b0, 1'b1, 1'($urandom), 1'($urandom), ins[t]);
                total++;
                if (state !== 4'(sq[k]) || reg_wr_ena !== (k == 3)) begin
                    bad++; $display("FAIL r_type[%0d] cyc%0d: state=%0d regw=%b want %0d/%b",
                                    t, k, state, reg_wr_ena, sq[k], (k == 3));
                end
                if (k == 2) begin
                    total++;
                    if (alu_control !== op[t]) begin
                        bad++; $display("FAIL r_type_alu[%0d]: got %b want %b", t, alu_control, op[t]);
                    end
                end
            end
        end
    endtask

    task automatic test_load_wait();
        state_t sq  [9] = '{S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_READ,
                            S_MEM_READ, S_MEM_READ, S_MEM_WB, S_FETCH};
        logic   rdy [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic   req [9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        int     writes;
        writes = 0;
        do_reset();
        for (int k = 0; k < 9; k++) begin
            cyc(1'b0, rdy[k], 1'b0, 1'b0, 32'h0040A283);
            if (reg_wr_ena === 1'b1) writes++;
            total++;
            if (state !== 4'(sq[k]) || mem_req !== req[k] || reg_wr_ena !== (k == 7)) begin
                bad++; $display("FAIL load_wait cyc%0d: state=%0d req=%b regw=%b want %0d/%b/%b",
                                k, state, mem_req, reg_wr_ena, sq[k], req[k], (k == 7));
            end
        end
        total++;
        if (writes != 1) begin
            bad++; $display("FAIL load_wait_writes: got %0d want 1", writes);
        end
    endtask

    task automatic test_branch();
        state_t sq [4] = '{S_FETCH, S_DECODE, S_BRANCH, S_FETCH};
        for (int e = 1; e >= 0; e--) begin
            do_reset();
            for (int k = 0; k < 4; k++) begin
                cyc(1'b0, 1'b1, 1'(e), 1'($urandom), 32'h00000063);
                total++;
                if (state !== 4'(sq[k]) || pc_ena !== ((k == 2) ? 1'(e) : (k != 1))) begin
                    bad++; $display("FAIL branch_eq%0d cyc%0d: state=%0d pc_ena=%b want %0d",
                                    e, k, state, pc_ena, sq[k]);
                end
            end
        end
    endtask

    task automatic test_illegal();
        do_reset();
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        total++;
        if (state !== 4'(S_DECODE)) begin
            bad++; $display("FAIL illegal_decode: state=%0d want %0d", state, S_DECODE);
        end
        for (int k = 0; k < 12; k++) begin
            cyc(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 32'h0);
            total++;
            if (state !== 4'(S_ERROR) || illegal !== 1'b1 ||
                {mem_req, mem_wr_ena, ir_ena, pc_ena, reg_wr_ena} !== 5'b0) begin
                bad++; $display("FAIL illegal_hold cyc%0d: state=%0d ill=%b en=%b want %0d/1/00000", k,
                                state, illegal, {mem_req, mem_wr_ena, ir_ena, pc_ena, reg_wr_ena}, S_ERROR);
            end
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        total++;
        if (state !== 4'(S_FETCH) || illegal !== 1'b0) begin
            bad++; $display("FAIL illegal_clear: state=%0d ill=%b want %0d/0", state, illegal, S_FETCH);
        end
    endtask

    // ---------------- random stream model ----------------
    obs_t       mv, mc;
    obs_t       qv [$];
    obs_t       qc [$];
    logic [3:0] qin [$];

    function automatic logic [3:0] ref_op(input int cls, input logic [2:0] f3, input logic b30);
        if (cls == 2) begin
            if (f3 == 3'd0 || f3 == 3'd1) return OPC_SUB;
            if (f3 == 3'd4 || f3 == 3'd5) return ALU_SLT;
            return ALU_SLTU;
        end
        case (f3)
            3'd0: return (cls == 0 && b30) ? OPC_SUB : OPC_ADD;
            3'd1: return ALU_SLL;
            3'd2: return ALU_SLT;
            3'd3: return ALU_SLTU;
            3'd4: return ALU_XOR;
            3'd5: return b30 ? ALU_SRA : ALU_SRL;
            3'd6: return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    task automatic rec(input state_t st);
        mv = '0; mc = '0;
        mv.st = 4'(st); mc.st = 4'hF;
        mv.ill = (st == S_ERROR);
        {mc.req, mc.wr, mc.ir, mc.pc, mc.regw, mc.ill} = 6'b111111;
    endtask

    task automatic sel(input logic [3:0] op, input logic [1:0] a, input logic [1:0] b);
        mv.alu = op; mc.alu = 4'hF; mv.ra = a; mc.ra = 2'b11; mv.rb = b; mc.rb = 2'b11;
    endtask

    task automatic set_imm(input logic [2:0] i);
        mv.imm = i; mc.imm = 3'b111;
    endtask

    task automatic set_res(input logic [1:0] r);
        mv.rs = r; mc.rs = 2'b11;
    endtask

    task automatic set_adr(input logic a);
        mv.adr = a; mc.adr = 1'b1;
    endtask

    task automatic commit(input logic r, input logic rdy, input logic eq, input logic lsb);
        qv.push_back(mv); qc.push_back(mc); qin.push_back({r, rdy, eq, lsb});
    endtask

    task automatic test_random();
        logic [2:0] lf [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        logic [2:0] bf [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        logic [2:0] xl [3] = '{3'd3, 3'd6, 3'd7};
        logic [6:0] uo [4] = '{7'b0010111, 7'b1110011, 7'b0000000, 7'b0001111};
        logic [31:0] ins;
        logic [2:0]  f3;
        logic [6:0]  opc;
        logic        eq, lsb, tk, rdy;
        int          cls, nw, cyc_n;
        obs_t        got, v, c;
        logic [3:0]  in;
        do_reset();
        for (int n = 0; n < 200; n++) begin
            cls = $urandom_range(0, 10);
            ins = $urandom;
            f3  = ins[14:12];
            opc = 7'b0110011;
            case (cls)
                1: opc = 7'b0010011;
                2: begin opc = 7'b0000011; f3 = lf[$urandom_range(0, 4)]; end
                3: begin opc = 7'b0100011; f3 = 3'($urandom_range(0, 2)); end
                4: begin opc = 7'b1100011; f3 = bf[$urandom_range(0, 5)]; end
                5: opc = 7'b1101111;
                6: opc = 7'b1100111;
                7: opc = 7'b0110111;
                8: if ($urandom_range(0, 1) == 0) begin
                       opc = 7'b0000011; f3 = xl[$urandom_range(0, 2)];
                   end else begin
                       opc = 7'b0100011; f3 = 3'($urandom_range(3, 7));
                   end
                9: begin opc = 7'b1100011; f3 = 3'($urandom_range(2, 3)); end
                10: opc = uo[$urandom_range(0, 3)];
                default: ;
            endcase
            ins[14:12] = f3;
            ins[6:0]   = opc;

            nw = $urandom_range(0, 2);
            for (int k = 0; k <= nw; k++) begin
                rdy = (k == nw);
                rec(S_FETCH); mv.req = 1'b1; mv.ir = rdy; mv.pc = rdy;
                sel(OPC_ADD, A_PC, B_FOUR); set_res(R_ALU); set_adr(1'b0);
                commit(1'b0, rdy, 1'($urandom), 1'($urandom));
            end
            rec(S_DECODE); sel(OPC_ADD, A_OLD, B_IMM); set_imm((cls == 5) ? I_J : I_B);
            commit(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));

            case (cls)
                0, 1: begin
                    rec(cls == 0 ? S_EXEC_R : S_EXEC_I);
                    sel(ref_op(cls, f3, ins[30]), A_RS1, cls == 0 ? B_RS2 : B_IMM);
                    if (cls == 1) set_imm(I_I);
                    commit(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
                end
                2, 3: begin
                    rec(S_MEM_ADR); sel(OPC_ADD, A_RS1, B_IMM); set_imm(cls == 2 ? I_I : I_S);
                    commit(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
                    nw = $urandom_range(0, 3);
                    for (int k = 0; k <= nw; k++) begin
                        rdy = (k == nw);
                        rec(cls == 2 ? S_MEM_READ : S_MEM_WRITE);
                        mv.req = 1'b1; mv.wr = (cls == 3); set_adr(1'b1);
                        if (cls == 2) set_res(R_AOUT);
                        commit(1'b0, rdy, 1'($urandom), 1'($urandom));
                    end
                    if (cls == 2) begin
                        rec(S_MEM_WB); mv.regw = 1'b1; set_res(R_MEM);
                        commit(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
                    end
                end
                4: begin
                    eq = 1'($urandom); lsb = 1'($urandom);
                    case (f3)
                        3'd0:       tk = eq;
                        3'd1:       tk = !eq;
                        3'd4, 3'd6: tk = lsb;
                        default:    tk = !lsb;
                    endcase
                    rec(S_BRANCH); sel(ref_op(2, f3, ins[30]), A_RS1, B_RS2);
                    set_res(R_AOUT); mv.pc = tk;
                    commit(1'b0, 1'($urandom), eq, lsb);
                end
                5: begin
                    rec(S_JAL); sel(OPC_ADD, A_OLD, B_FOUR); set_res(R_AOUT); mv.pc = 1'b1;
                    commit(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
                end
                6: begin
                    rec(S_JALR); sel(OPC_ADD, A_RS1, B_IMM); set_imm(I_I); set_res(R_ALU); mv.pc = 1'b1;
                    commit(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
                    rec(S_JALR_WB); sel(OPC_ADD, A_OLD, B_FOUR); set_res(R_ALU); mv.regw = 1'b1;
                    commit(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
                end
                7: begin
                    rec(S_LUI); sel(OPC_ADD, A_ZERO, B_IMM); set_imm(I_U);
                    commit(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
                end
                default: begin
                    for (int k = 0; k < 3; k++) begin
                        rec(S_ERROR);
                        commit(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
                    end
                    rec(S_ERROR); mc.st = 4'h0; mc.ill = 1'b0;
                    sel(OPC_ADD, 2'b00, 2'b00); set_imm(3'd0); set_res(2'b00); set_adr(1'b0);
                    commit(1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
                end
            endcase
            if (cls <= 1 || cls == 5 || cls == 7) begin
                rec(S_ALU_WB); mv.regw = 1'b1; set_res(R_AOUT);
                commit(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
            end

            cyc_n = 0;
            while (qv.size() > 0) begin
                v = qv.pop_front(); c = qc.pop_front(); in = qin.pop_front();
                cyc(in[3], in[2], in[1], in[0], ins);
                got = sample();
                total++;
                if ((got & c) !== (v & c)) begin
                    bad++;
                    $display("FAIL random[%0d] instr=%h cyc%0d: got %h want %h (care %h)",
                             n, ins, cyc_n, got, v, c);
                end
                cyc_n++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_r_type();
        test_load_wait();
        test_branch();
        test_illegal();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
